// File: rtl/mips_pkg.sv
// Shared MIPS definitions: field widths, opcode constants and the control bundle.
package mips_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;

    // Control bundle, MSB first: reg_wr, alu_src, branch, memread, memwrite, memtoreg.
    typedef struct packed {
        logic reg_wr;
        logic alu_src;
        logic branch;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } ctrl_t;

    // Which instruction field names the destination register.
    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RT   = 2'd1,
        DEST_RD   = 2'd2
    } dest_sel_e;

    // Everything the opcode alone determines.
    typedef struct packed {
        ctrl_t     ctrl;
        dest_sel_e dest;
        logic      zero_ext;
        logic      uses_rt;
    } dec_t;

    function automatic dec_t decode_op(input logic [OPCODE_WIDTH-1:0] op);
        dec_t d;
        d = '0;
        d.dest = DEST_NONE;
        case (op)
            OP_RTYPE: begin
                d.ctrl.reg_wr = 1'b1;
                d.dest        = DEST_RD;
                d.uses_rt     = 1'b1;
            end
            OP_LW: begin
                d.ctrl.reg_wr   = 1'b1;
                d.ctrl.alu_src  = 1'b1;
                d.ctrl.memread  = 1'b1;
                d.ctrl.memtoreg = 1'b1;
                d.dest          = DEST_RT;
            end
            OP_SW: begin
                d.ctrl.alu_src  = 1'b1;
                d.ctrl.memwrite = 1'b1;
                d.uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                d.ctrl.branch = 1'b1;
                d.uses_rt     = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                d.ctrl.reg_wr  = 1'b1;
                d.ctrl.alu_src = 1'b1;
                d.dest         = DEST_RT;
            end
            OP_ANDI, OP_ORI: begin
                d.ctrl.reg_wr  = 1'b1;
                d.ctrl.alu_src = 1'b1;
                d.dest         = DEST_RT;
                d.zero_ext     = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// 2-read/1-write register file with reset clear, hardwired register 0 and
// optional same-cycle writeback bypass onto the read ports.
module regfile_bypass
    import mips_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr_a,
    input  logic [AWIDTH-1:0] rd_addr_b,
    output logic [DWIDTH-1:0] rd_data_a,
    output logic [DWIDTH-1:0] rd_data_b
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] mem_d [DEPTH];

    function automatic logic [DWIDTH-1:0] read_port(input logic [AWIDTH-1:0] addr);
        logic [DWIDTH-1:0] r;
        if (addr == '0) begin
            r = '0;
        end else if (FWD_EN && wr_en && (wr_addr == addr)) begin
            r = wr_data;
        end else begin
            r = mem_q[addr];
        end
        return r;
    endfunction

    // Next-state of the array: one write per cycle, register 0 never written.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr != '0)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage; reset wins over a concurrent writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports with register-0 forcing and optional bypass.
    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, register read, load-use hazard
// detection and the ID/EX pipeline register.
module id_stage
    import mips_pkg::*;
#(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 32,
    parameter int IWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter bit FWD_EN    = 1'b1
) (
    input  logic                    id_clk,
    input  logic                    id_rst,
    input  logic                    id_i_valid,
    input  logic [IWIDTH-1:0]       id_i_instr,
    input  logic                    id_i_flush,
    input  logic                    id_i_wb_en,
    input  logic [AWIDTH-1:0]       id_i_wb_addr,
    input  logic [DWIDTH-1:0]       id_i_wb_data,
    output logic                    id_o_stall,
    output logic                    id_o_valid,
    output logic [OPCODE_WIDTH-1:0] id_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  id_o_funct,
    output logic [DWIDTH-1:0]       id_o_data_rs,
    output logic [DWIDTH-1:0]       id_o_data_rt,
    output logic [DWIDTH-1:0]       id_o_imm,
    output logic [AWIDTH-1:0]       id_o_addr_rs,
    output logic [AWIDTH-1:0]       id_o_addr_rt,
    output logic [AWIDTH-1:0]       id_o_addr_wr,
    output logic                    id_o_reg_wr,
    output logic                    id_o_alu_src,
    output logic                    id_o_branch,
    output logic                    id_o_memread,
    output logic                    id_o_memwrite,
    output logic                    id_o_memtoreg
);

    localparam int OPC_LSB = IWIDTH - OPCODE_WIDTH;
    localparam int RS_LSB  = OPC_LSB - AWIDTH;
    localparam int RT_LSB  = RS_LSB - AWIDTH;
    localparam int RD_LSB  = RT_LSB - AWIDTH;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [FUNCT_WIDTH-1:0]  funct;
    logic [AWIDTH-1:0]       rs, rt, rd;
    logic [IMM_WIDTH-1:0]    imm_raw;
    logic [DWIDTH-1:0]       imm_ext;
    logic [AWIDTH-1:0]       dest;
    dec_t                    dec;
    logic [DWIDTH-1:0]       rf_rs, rf_rt;
    logic                    hazard;
    logic                    stall;

    logic                    valid_q,  valid_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [FUNCT_WIDTH-1:0]  funct_q,  funct_d;
    logic [DWIDTH-1:0]       data_rs_q, data_rs_d;
    logic [DWIDTH-1:0]       data_rt_q, data_rt_d;
    logic [DWIDTH-1:0]       imm_q,    imm_d;
    logic [AWIDTH-1:0]       addr_rs_q, addr_rs_d;
    logic [AWIDTH-1:0]       addr_rt_q, addr_rt_d;
    logic [AWIDTH-1:0]       addr_wr_q, addr_wr_d;
    ctrl_t                   ctrl_q,   ctrl_d;

    // Field extraction, control decode, immediate extension and destination select.
    always_comb begin
        opcode  = id_i_instr[OPC_LSB +: OPCODE_WIDTH];
        rs      = id_i_instr[RS_LSB +: AWIDTH];
        rt      = id_i_instr[RT_LSB +: AWIDTH];
        rd      = id_i_instr[RD_LSB +: AWIDTH];
        funct   = id_i_instr[FUNCT_WIDTH-1:0];
        imm_raw = id_i_instr[IMM_WIDTH-1:0];
        dec     = decode_op(opcode);
        if (dec.zero_ext) begin
            imm_ext = {{(DWIDTH-IMM_WIDTH){1'b0}}, imm_raw};
        end else begin
            imm_ext = {{(DWIDTH-IMM_WIDTH){imm_raw[IMM_WIDTH-1]}}, imm_raw};
        end
        case (dec.dest)
            DEST_RT: dest = rt;
            DEST_RD: dest = rd;
            default: dest = '0;
        endcase
    end

    regfile_bypass #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH),
        .FWD_EN (FWD_EN)
    ) u_regfile (
        .clk       (id_clk),
        .rst       (id_rst),
        .wr_en     (id_i_wb_en),
        .wr_addr   (id_i_wb_addr),
        .wr_data   (id_i_wb_data),
        .rd_addr_a (rs),
        .rd_addr_b (rt),
        .rd_data_a (rf_rs),
        .rd_data_b (rf_rt)
    );

    // Load-use hazard against the load sitting in ID/EX; a flush overrides the stall.
    always_comb begin
        hazard = id_i_valid && valid_q && ctrl_q.memread && (addr_wr_q != '0) &&
                 ((addr_wr_q == rs) || (dec.uses_rt && (addr_wr_q == rt)));
        stall  = hazard && !id_i_flush;
    end

    assign id_o_stall = stall;

    // ID/EX next value: a zeroed bubble unless a valid, unstalled, unflushed instruction arrives.
    always_comb begin
        valid_d   = 1'b0;
        opcode_d  = '0;
        funct_d   = '0;
        data_rs_d = '0;
        data_rt_d = '0;
        imm_d     = '0;
        addr_rs_d = '0;
        addr_rt_d = '0;
        addr_wr_d = '0;
        ctrl_d    = '0;
        if (id_i_valid && !id_i_flush && !stall) begin
            valid_d   = 1'b1;
            opcode_d  = opcode;
            funct_d   = funct;
            data_rs_d = rf_rs;
            data_rt_d = rf_rt;
            imm_d     = imm_ext;
            addr_rs_d = rs;
            addr_rt_d = rt;
            addr_wr_d = dest;
            ctrl_d    = dec.ctrl;
        end
    end

    // ID/EX pipeline register with synchronous reset.
    always_ff @(posedge id_clk) begin
        if (id_rst) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            funct_q   <= '0;
            data_rs_q <= '0;
            data_rt_q <= '0;
            imm_q     <= '0;
            addr_rs_q <= '0;
            addr_rt_q <= '0;
            addr_wr_q <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            data_rs_q <= data_rs_d;
            data_rt_q <= data_rt_d;
            imm_q     <= imm_d;
            addr_rs_q <= addr_rs_d;
            addr_rt_q <= addr_rt_d;
            addr_wr_q <= addr_wr_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign id_o_valid    = valid_q;
    assign id_o_opcode   = opcode_q;
    assign id_o_funct    = funct_q;
    assign id_o_data_rs  = data_rs_q;
    assign id_o_data_rt  = data_rt_q;
    assign id_o_imm      = imm_q;
    assign id_o_addr_rs  = addr_rs_q;
    assign id_o_addr_rt  = addr_rt_q;
    assign id_o_addr_wr  = addr_wr_q;
    assign id_o_reg_wr   = ctrl_q.reg_wr;
    assign id_o_alu_src  = ctrl_q.alu_src;
    assign id_o_branch   = ctrl_q.branch;
    assign id_o_memread  = ctrl_q.memread;
    assign id_o_memwrite = ctrl_q.memwrite;
    assign id_o_memtoreg = ctrl_q.memtoreg;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random traffic, with two DUT
// copies (bypass on and off) compared against a behavioural pipeline model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_instr;
    logic        i_flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        stall_f, valid_f, rw_f, as_f, br_f, mr_f, mw_f, mt_f;
    logic [5:0]  op_f, fn_f;
    logic [31:0] drs_f, drt_f, imm_f;
    logic [4:0]  ars_f, art_f, awr_f;

    logic        stall_n, valid_n, rw_n, as_n, br_n, mr_n, mw_n, mt_n;
    logic [5:0]  op_n, fn_n;
    logic [31:0] drs_n, drt_n, imm_n;
    logic [4:0]  ars_n, art_n, awr_n;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    id_stage #(.FWD_EN(1'b1)) u_dut (
        .id_clk(clk), .id_rst(rst), .id_i_valid(i_valid), .id_i_instr(i_instr),
        .id_i_flush(i_flush), .id_i_wb_en(wb_en), .id_i_wb_addr(wb_addr),
        .id_i_wb_data(wb_data), .id_o_stall(stall_f), .id_o_valid(valid_f),
        .id_o_opcode(op_f), .id_o_funct(fn_f), .id_o_data_rs(drs_f),
        .id_o_data_rt(drt_f), .id_o_imm(imm_f), .id_o_addr_rs(ars_f),
        .id_o_addr_rt(art_f), .id_o_addr_wr(awr_f), .id_o_reg_wr(rw_f),
        .id_o_alu_src(as_f), .id_o_branch(br_f), .id_o_memread(mr_f),
        .id_o_memwrite(mw_f), .id_o_memtoreg(mt_f)
    );

    id_stage #(.FWD_EN(1'b0)) u_dut_nf (
        .id_clk(clk), .id_rst(rst), .id_i_valid(i_valid), .id_i_instr(i_instr),
        .id_i_flush(i_flush), .id_i_wb_en(wb_en), .id_i_wb_addr(wb_addr),
        .id_i_wb_data(wb_data), .id_o_stall(stall_n), .id_o_valid(valid_n),
        .id_o_opcode(op_n), .id_o_funct(fn_n), .id_o_data_rs(drs_n),
        .id_o_data_rt(drt_n), .id_o_imm(imm_n), .id_o_addr_rs(ars_n),
        .id_o_addr_rt(art_n), .id_o_addr_wr(awr_n), .id_o_reg_wr(rw_n),
        .id_o_alu_src(as_n), .id_o_branch(br_n), .id_o_memread(mr_n),
        .id_o_memwrite(mw_n), .id_o_memtoreg(mt_n)
    );

    // Reference model state: architectural registers and the expected ID/EX contents.
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [5:0]  m_op, m_fn;
    logic [31:0] m_drs_f, m_drt_f, m_drs_n, m_drt_n, m_imm;
    logic [4:0]  m_ars, m_art, m_awr;
    logic [5:0]  m_ctl;   // {reg_wr, alu_src, branch, memread, memwrite, memtoreg}
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_op = '0; m_fn = '0; m_imm = '0;
        m_drs_f = '0; m_drt_f = '0; m_drs_n = '0; m_drt_n = '0;
        m_ars = '0; m_art = '0; m_awr = '0; m_ctl = '0;
    endtask

    task automatic compare_outputs();
        chk("valid",    32'(valid_f), 32'(m_valid));
        chk("opcode",   32'(op_f),    32'(m_op));
        chk("funct",    32'(fn_f),    32'(m_fn));
        chk("data_rs",  drs_f,        m_drs_f);
        chk("data_rt",  drt_f,        m_drt_f);
        chk("imm",      imm_f,        m_imm);
        chk("addr_rs",  32'(ars_f),   32'(m_ars));
        chk("addr_rt",  32'(art_f),   32'(m_art));
        chk("addr_wr",  32'(awr_f),   32'(m_awr));
        chk("ctrl",     32'({rw_f, as_f, br_f, mr_f, mw_f, mt_f}), 32'(m_ctl));
        chk("nf_valid", 32'(valid_n), 32'(m_valid));
        chk("nf_data_rs", drs_n,      m_drs_n);
        chk("nf_data_rt", drt_n,      m_drt_n);
        chk("nf_imm",   imm_n,        m_imm);
        chk("nf_addr",  32'({op_n, fn_n, ars_n, art_n, awr_n}),
                        32'({m_op, m_fn, m_ars, m_art, m_awr}));
        chk("nf_ctrl",  32'({rw_n, as_n, br_n, mr_n, mw_n, mt_n}), 32'(m_ctl));
    endtask

    // One clock: drive, check the combinational stall, advance model, check ID/EX.
    task automatic step(input logic r, input logic v, input logic [31:0] instr,
                        input logic fl, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, dst;
        logic [15:0] i16;
        logic [5:0]  ctl;
        logic        urt, zext, haz, exp_stall;
        logic [31:0] rsf, rtf, rsn, rtn;
        @(negedge clk);
        rst = r; i_valid = v; i_instr = instr; i_flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
        i16 = instr[15:0];
        ctl = '0; urt = 1'b0; zext = 1'b0; dst = '0;
        case (op)
            6'h00: begin ctl = 6'b100000; urt = 1'b1; dst = rd; end
            6'h23: begin ctl = 6'b110101; dst = rt; end
            6'h2B: begin ctl = 6'b010010; urt = 1'b1; end
            6'h04: begin ctl = 6'b001000; urt = 1'b1; end
            6'h08, 6'h0A: begin ctl = 6'b110000; dst = rt; end
            6'h0C, 6'h0D: begin ctl = 6'b110000; zext = 1'b1; dst = rt; end
            default: ctl = '0;
        endcase
        haz = v && m_valid && m_ctl[2] && (m_awr != 0) &&
              ((m_awr == rs) || (urt && (m_awr == rt)));
        exp_stall = haz && !fl;
        last_stall = stall_f;
        chk("stall",    32'(stall_f), 32'(exp_stall));
        chk("nf_stall", 32'(stall_n), 32'(exp_stall));
        rsn = m_rf[rs];
        rtn = m_rf[rt];
        rsf = (we && wa == rs && rs != 0) ? wd : m_rf[rs];
        rtf = (we && wa == rt && rt != 0) ? wd : m_rf[rt];
        if (r) begin
            model_clear();
            for (int k = 0; k < 32; k++) m_rf[k] = '0;
        end else begin
            if (fl || exp_stall || !v) begin
                model_clear();
            end else begin
                m_valid = 1'b1; m_op = op; m_fn = instr[5:0];
                m_drs_f = rsf; m_drt_f = rtf; m_drs_n = rsn; m_drt_n = rtn;
                m_imm = zext ? {16'h0, i16} : {{16{i16[15]}}, i16};
                m_ars = rs; m_art = rt; m_awr = dst; m_ctl = ctl;
            end
            if (we && wa != 0) m_rf[wa] = wd;
        end
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    localparam logic [31:0] I_ADDI1   = 32'h2001FFFD; // addi $1,$0,-3
    localparam logic [31:0] I_ADD655  = 32'h00A53020; // add $6,$5,$5
    localparam logic [31:0] I_LW2     = 32'h8C220000; // lw $2,0($1)
    localparam logic [31:0] I_ADD324  = 32'h00441820; // add $3,$2,$4
    localparam logic [31:0] I_SW2     = 32'hAC220000; // sw $2,0($1)
    localparam logic [31:0] I_LW4     = 32'h8C240000; // lw $4,0($1)
    localparam logic [31:0] I_ADDI341 = 32'h20830001; // addi $3,$4,1
    localparam logic [31:0] I_OR700   = 32'h00003825; // or $7,$0,$0
    localparam logic [31:0] I_ORI8    = 32'h34088000; // ori $8,$0,0x8000
    localparam logic [31:0] I_ILL     = 32'hFC000000; // opcode 0x3F

    logic [5:0] op_pool [9];

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_instr = '0; i_flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        last_stall = 1'b0;
        model_clear();
        for (int k = 0; k < 32; k++) m_rf[k] = '0;

        // Reset (with a WB write that must be ignored), then addi.
        step(1, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
        chk("rst_valid", 32'(valid_f), 32'd0);
        chk("rst_stall", 32'(stall_f), 32'd0);
        step(0, 1, I_ADDI1, 0, 0, 0, 0);
        chk("addi_valid", 32'(valid_f), 32'd1);
        chk("addi_wr",    32'(awr_f),   32'd1);
        chk("addi_imm",   imm_f,        32'hFFFF_FFFD);
        chk("addi_ctl",   32'({rw_f, as_f}), 32'b11);
        chk("addi_rs",    drs_f,        32'd0);

        // Same-cycle writeback bypass.
        step(0, 1, I_ADD655, 0, 1, 5'd5, 32'h0000_1234);
        chk("byp_rs",    drs_f, 32'h1234);
        chk("byp_rt",    drt_f, 32'h1234);
        chk("nobyp_rs",  drs_n, 32'h0);
        chk("nobyp_rt",  drt_n, 32'h0);

        // Load-use: one stall, bubble, then the dependent add.
        step(0, 1, I_LW2, 0, 0, 0, 0);
        step(0, 1, I_ADD324, 0, 0, 0, 0);
        chk("lu_stall",  32'(last_stall), 32'd1);
        chk("lu_bub_v",  32'(valid_f),    32'd0);
        chk("lu_bub_mr", 32'(mr_f),       32'd0);
        step(0, 1, I_ADD324, 0, 0, 0, 0);
        chk("lu_stall2", 32'(last_stall), 32'd0);
        chk("lu_add_v",  32'(valid_f),    32'd1);
        chk("lu_add_wr", 32'(awr_f),      32'd3);

        step(0, 1, I_LW2, 0, 0, 0, 0);
        step(0, 1, I_SW2, 0, 0, 0, 0);
        chk("lu_sw_stall", 32'(last_stall), 32'd1);
        step(0, 1, I_SW2, 0, 0, 0, 0);
        step(0, 1, I_LW4, 0, 0, 0, 0);
        step(0, 1, I_ADDI341, 0, 0, 0, 0);
        chk("lu_addi_stall", 32'(last_stall), 32'd1);
        step(0, 1, I_ADDI341, 0, 0, 0, 0);

        // Flush beats a hazard.
        step(0, 1, I_LW2, 0, 0, 0, 0);
        step(0, 1, I_ADD324, 1, 0, 0, 0);
        chk("fl_stall", 32'(last_stall), 32'd0);
        chk("fl_valid", 32'(valid_f),    32'd0);

        // Register 0 stays zero; ori zero-extends.
        step(0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        step(0, 1, I_OR700, 0, 0, 0, 0);
        chk("r0_rs", drs_f, 32'h0);
        chk("r0_rt", drt_f, 32'h0);
        step(0, 1, I_ORI8, 0, 0, 0, 0);
        chk("ori_imm", imm_f, 32'h0000_8000);

        // Illegal opcode: valid with no controls.
        step(0, 1, I_ILL, 0, 0, 0, 0);
        chk("ill_valid", 32'(valid_f), 32'd1);
        chk("ill_ctl",   32'({rw_f, as_f, br_f, mr_f, mw_f, mt_f}), 32'd0);

        // Reset during a stall clears everything including the register file.
        step(0, 1, I_LW2, 0, 0, 0, 0);
        step(1, 1, I_ADD324, 0, 0, 0, 0);
        chk("mr_stall_pre", 32'(last_stall), 32'd1);
        chk("mr_valid",     32'(valid_f),    32'd0);
        step(0, 1, I_ADD655, 0, 0, 0, 0);
        chk("mr_stall_post", 32'(last_stall), 32'd0);
        chk("mr_cleared",    drs_f,           32'd0);

        // Random traffic on a small register window to provoke hazards and bypasses.
        op_pool[0] = 6'h00; op_pool[1] = 6'h23; op_pool[2] = 6'h2B;
        op_pool[3] = 6'h04; op_pool[4] = 6'h08; op_pool[5] = 6'h0A;
        op_pool[6] = 6'h0C; op_pool[7] = 6'h0D; op_pool[8] = 6'h3F;
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ins;
            logic [5:0]  rop;
            rop = op_pool[$urandom_range(0, 8)];
            if ($urandom_range(0, 15) == 0) rop = 6'($urandom);
            ins = {rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   16'($urandom)};
            if (rop == 6'h00) ins[15:11] = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) != 0),
                 ins,
                 ($urandom_range(0, 9) == 0),
                 1'($urandom),
                 5'($urandom_range(0, 7)),
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
